// File: rtl/booth_mac_accumulator.sv
// Frame accumulator for signed 16-bit Booth products: sums N_TERMS products, then holds the result until downstream accepts it.
// Define BOOTH_MAC_SAT_EN for saturating addition with a sticky ovf flag; otherwise the sum wraps and ovf is 0.
module booth_mac_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [15:0]      prod_data,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  input  logic                    clear,
  output logic signed [ACC_W-1:0] acc_data,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic                    ovf
);

  localparam int DATA_W = 16;
  localparam logic [7:0] LAST_TERM = 8'(N_TERMS - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt, acc_data_nxt, sum;
  logic [7:0]              cnt, cnt_nxt;
  logic                    ovf_q, ovf_nxt, ovf_add;

`ifdef BOOTH_MAC_SAT_EN
  // Returns {overflow, clamped sum}; one guard bit exposes signed overflow.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [DATA_W-1:0] b);
    logic signed [ACC_W:0] ext;
    ext = {a[ACC_W-1], a} + {{(ACC_W+1-DATA_W){b[DATA_W-1]}}, b};
    if (ext[ACC_W] != ext[ACC_W-1])
      sat_add = {1'b1, ext[ACC_W], {(ACC_W-1){~ext[ACC_W]}}};
    else
      sat_add = {1'b0, ext[ACC_W-1:0]};
  endfunction

  assign {ovf_add, sum} = sat_add(acc, prod_data);
  assign ovf = ovf_q;
`else
  function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    wrap_add = a + {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
  endfunction

  assign sum     = wrap_add(acc, prod_data);
  assign ovf_add = 1'b0;
  assign ovf     = 1'b0;
`endif

  assign prod_ready = rst_n && (state == ACCUM) && !clear;
  assign acc_valid  = (state == HOLD);

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    acc_data_nxt = acc_data;
    ovf_nxt      = ovf_q;
    if (clear) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (prod_valid) begin
            acc_nxt = sum;
            ovf_nxt = ovf_q | ovf_add;
            if (cnt == LAST_TERM) begin
              state_nxt    = HOLD;
              acc_data_nxt = sum;
            end else begin
              cnt_nxt = cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      acc_data <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      acc_data <= acc_data_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Bench for booth_mac_accumulator: frame table with a scoreboard queue, plus hand-written hold/clear/reset/overflow sequences.
module tb_booth_mac_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic signed [15:0] prod_data;
  logic               prod_valid, prod_ready, clear, acc_valid, acc_ready, ovf;
  logic signed [23:0] acc_data;

  logic signed [15:0] prod_data17;
  logic               prod_valid17, prod_ready17, clear17, acc_valid17, acc_ready17, ovf17;
  logic signed [16:0] acc_data17;

  logic signed [15:0] prod_data1;
  logic               prod_valid1, prod_ready1, clear1, acc_valid1, acc_ready1, ovf1;
  logic signed [23:0] acc_data1;

  booth_mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .prod_data(prod_data), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .clear(clear), .acc_data(acc_data), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .ovf(ovf)
  );

  booth_mac_accumulator #(.N_TERMS(4), .ACC_W(17)) dut17 (
    .clk(clk), .rst_n(rst_n), .prod_data(prod_data17), .prod_valid(prod_valid17),
    .prod_ready(prod_ready17), .clear(clear17), .acc_data(acc_data17), .acc_valid(acc_valid17),
    .acc_ready(acc_ready17), .ovf(ovf17)
  );

  booth_mac_accumulator #(.N_TERMS(1), .ACC_W(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .prod_data(prod_data1), .prod_valid(prod_valid1),
    .prod_ready(prod_ready1), .clear(clear1), .acc_data(acc_data1), .acc_valid(acc_valid1),
    .acc_ready(acc_ready1), .ovf(ovf1)
  );

  typedef struct packed {
    logic [3:0][15:0] p;
    logic [23:0]      exp;
  } frame_t;

  frame_t      tbl [6];
  logic [23:0] exp_q [$];
  int          checks = 0, errors = 0, pushed = 0, delivered = 0;
  time         t_first, t_last;
  logic [16:0] exp17_pos, exp17_neg;
  logic        exp17_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] p);
    int k;
    k = 0;
    @(negedge clk);
    prod_valid = 1'b1;
    prod_data  = p;
    #1;
    while (!prod_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!prod_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: prod_ready %0b required 1", prod_ready);
    end else begin
      @(posedge clk);
      t_last = $time;
    end
  endtask

  // Scoreboard: a frame is delivered on the edge following a negedge with valid and ready both high
  always @(negedge clk) begin
    #2;
    if (rst_n && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %0h required no frame", acc_data);
      end else begin
        chk("frame_sum", $unsigned(acc_data), exp_q.pop_front());
        delivered++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0].p = {16'd1, 16'd1, 16'd1, 16'd1};                 tbl[0].exp = 24'd4;
    tbl[1].p = {16'd7, 16'd100, 16'hFFFE, 16'd3};            tbl[1].exp = 24'd108;
    tbl[2].p = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};     tbl[2].exp = 24'hFFFFFC;
    tbl[3].p = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};     tbl[3].exp = 24'h01FFFC;
    tbl[4].p = {16'h8000, 16'h8000, 16'h8000, 16'h8000};     tbl[4].exp = 24'hFE0000;
    tbl[5].p = {16'hFFFB, 16'd5, 16'hEDCC, 16'h1234};        tbl[5].exp = 24'd0;
`ifdef BOOTH_MAC_SAT_EN
    exp17_pos = 17'h0FFFF; exp17_neg = 17'h10000; exp17_ovf = 1'b1;
`else
    exp17_pos = 17'h1FFFC; exp17_neg = 17'h00000; exp17_ovf = 1'b0;
`endif

    rst_n = 1'b1;
    prod_data = '0;   prod_valid = 1'b0;   clear = 1'b0;   acc_ready = 1'b0;
    prod_data17 = '0; prod_valid17 = 1'b0; clear17 = 1'b0; acc_ready17 = 1'b0;
    prod_data1 = '0;  prod_valid1 = 1'b0;  clear1 = 1'b0;  acc_ready1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_acc_data", $unsigned(acc_data), 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_prod_ready", prod_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_prod_ready", prod_ready, 1);

    // Frame completes with downstream stalled; held product must not be consumed
    exp_q.push_back(24'd108); pushed++;
    send(16'd3); send(16'hFFFE); send(16'd100); send(16'd7);
    @(negedge clk);
    prod_valid = 1'b1; prod_data = 16'd1;
    #1;
    chk("hold_acc_valid", acc_valid, 1);
    chk("hold_acc_data", $unsigned(acc_data), 24'd108);
    chk("hold_prod_ready", prod_ready, 0);
    chk("hold_ovf", ovf, 0);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("stall_acc_data", $unsigned(acc_data), 24'd108);
      chk("stall_prod_ready", prod_ready, 0);
    end
    @(negedge clk);
    acc_ready = 1'b1;

    // Back-to-back frames with acc_ready held high
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(tbl[i].exp); pushed++;
      for (int j = 0; j < 4; j++) begin
        send(tbl[i].p[j]);
        if (i == 0 && j == 0) t_first = t_last;
      end
    end
    chk("throughput_time", 32'(t_last - t_first), 32'((5 * 5 + 3) * 10));
    @(negedge clk);
    prod_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("idle_acc_valid", acc_valid, 0);

    // clear drops the partial frame and the coincident product
    send(16'd50); send(16'd60);
    @(negedge clk);
    clear = 1'b1; prod_valid = 1'b1; prod_data = 16'd70;
    #1 chk("clear_prod_ready", prod_ready, 0);
    @(negedge clk);
    clear = 1'b0; prod_valid = 1'b0;
    #1 chk("clear_acc_valid", acc_valid, 0);
    exp_q.push_back(24'd10); pushed++;
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    @(negedge clk);
    prod_valid = 1'b0;
    @(negedge clk);

    // clear while holding an undelivered frame
    acc_ready = 1'b0;
    send(16'd9); send(16'd9); send(16'd9); send(16'd9);
    @(negedge clk);
    prod_valid = 1'b0;
    #1 chk("hold9_acc_valid", acc_valid, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clear_hold_acc_valid", acc_valid, 0);
    chk("clear_hold_prod_ready", prod_ready, 1);
    acc_ready = 1'b1;

    // Asynchronous reset mid-frame
    send(16'd5); send(16'd5);
    @(negedge clk);
    prod_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_acc_data", $unsigned(acc_data), 0);
    chk("midrst_acc_valid", acc_valid, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_prod_ready", prod_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_release_ready", prod_ready, 1);
    exp_q.push_back(24'd20); pushed++;
    send(16'd5); send(16'd5); send(16'd5); send(16'd5);
    @(negedge clk);
    prod_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("queue_empty", exp_q.size(), 0);
    chk("delivered_count", delivered, pushed);

    // 17-bit accumulator: positive then negative overflow
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      prod_valid17 = 1'b1; prod_data17 = 16'h7FFF;
    end
    @(negedge clk);
    prod_valid17 = 1'b0;
    #1;
    chk("w17_pos_valid", acc_valid17, 1);
    chk("w17_pos_data", $unsigned(acc_data17), exp17_pos);
    chk("w17_pos_ovf", ovf17, exp17_ovf);
    acc_ready17 = 1'b1;
    @(negedge clk);
    acc_ready17 = 1'b0;
    #1;
    chk("w17_ovf_cleared", ovf17, 0);
    chk("w17_valid_cleared", acc_valid17, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      prod_valid17 = 1'b1; prod_data17 = 16'h8000;
    end
    @(negedge clk);
    prod_valid17 = 1'b0;
    #1;
    chk("w17_neg_data", $unsigned(acc_data17), exp17_neg);
    chk("w17_neg_ovf", ovf17, exp17_ovf);

    // Single-term frames
    @(negedge clk);
    prod_valid1 = 1'b1; prod_data1 = 16'd5;
    @(negedge clk);
    #1;
    chk("n1_valid", acc_valid1, 1);
    chk("n1_data", $unsigned(acc_data1), 24'd5);
    chk("n1_hold_ready", prod_ready1, 0);
    acc_ready1 = 1'b1; prod_data1 = 16'hFFFD;
    @(negedge clk);
    #1;
    chk("n1_ready_after", prod_ready1, 1);
    chk("n1_valid_low", acc_valid1, 0);
    chk("n1_keeps_data", $unsigned(acc_data1), 24'd5);
    @(negedge clk);
    prod_valid1 = 1'b0;
    #1;
    chk("n1_second_valid", acc_valid1, 1);
    chk("n1_second_data", $unsigned(acc_data1), 24'hFFFFFD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
